// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding imem request, small prefetch FIFO, branch flush.
// Optional stall counter port stall_cnt_o is built when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [WORD_WIDTH-1:0] NOOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_address_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  input  logic                  id_ready_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] instr_pc_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_REQ_KILL,
    S_DROP
  } state_t;

  state_t                  state, state_nxt;
  logic [WORD_WIDTH-1:0]   next_addr;
  logic [WORD_WIDTH-1:0]   req_addr;
  logic [WORD_WIDTH-1:0]   fifo_instr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        eff_count;
  logic [WORD_WIDTH-1:0]   target_al, start_al;
  logic                    outstanding, credit, push, pop, load_req;

  assign target_al   = branch_target_i & ~WORD_WIDTH'(3);
  assign start_al    = pc_start_address_i & ~WORD_WIDTH'(3);
  assign outstanding = (state == S_WAIT) || (state == S_DROP);
  // A branch empties the FIFO on this edge, so credit is judged against an empty buffer.
  assign eff_count   = branch_i ? '0 : count;
  assign credit      = fetch_en_i && ((int'(eff_count) + int'(outstanding)) < FIFO_DEPTH);
  assign push        = (state == S_WAIT) && instr_rvalid_i && !branch_i;
  assign pop         = instr_valid_o && id_ready_i && !branch_i;

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (credit) begin
          state_nxt = S_REQ;
          load_req  = 1'b1;
        end
      end
      S_REQ: begin
        if (instr_gnt_i)   state_nxt = branch_i ? S_DROP : S_WAIT;
        else if (branch_i) state_nxt = S_REQ_KILL;
      end
      S_WAIT: begin
        if (instr_rvalid_i) begin
          state_nxt = credit ? S_REQ : S_IDLE;
          load_req  = credit;
        end else if (branch_i) begin
          state_nxt = S_DROP;
        end
      end
      S_REQ_KILL: begin
        if (instr_gnt_i) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (instr_rvalid_i) begin
          state_nxt = credit ? S_REQ : S_IDLE;
          load_req  = credit;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      next_addr <= '0;
      req_addr  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (branch_i)                             next_addr <= target_al;
      else if (state == S_REQ && instr_gnt_i)   next_addr <= req_addr + WORD_WIDTH'(4);
      else if (state == S_IDLE && !fetch_en_i)  next_addr <= start_al;
      if (load_req) req_addr <= branch_i ? target_al : next_addr;
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= instr_rdata_i;
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end

  assign instr_req_o   = (state == S_REQ) || (state == S_REQ_KILL);
  assign instr_addr_o  = req_addr;
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : NOOP_INSTR;
  assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr] : '0;

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (fetch_en_i && id_ready_i && !instr_valid_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle table, hand sequences, randomized run against a stream model.
module tb_if_fetch_ctrl;
  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] pc_start;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        branch;
  logic [31:0] target;
  logic        id_ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  if_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .pc_start_address_i(pc_start),
    .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt), .instr_rvalid_i(rvalid),
    .instr_rdata_i(rdata), .branch_i(branch), .branch_target_i(target), .id_ready_i(id_ready),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(instr_pc)
`ifdef IF_FETCH_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_en = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    branch = 1'b0; target = '0; id_ready = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] start);
    idle_inputs();
    pc_start = start;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, NOOP);
    chk("rst_pc", instr_pc, 32'd0);
`ifdef IF_FETCH_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        fe, g, rv;
    logic [31:0] rd;
    logic        br;
    logic [31:0] tg;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic vec_t mk(input logic fe, g, rv, input logic [31:0] rd, input logic br,
                              input logic [31:0] tg, input logic rdy, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, e_instr);
    vec_t v;
    v.fe = fe; v.g = g; v.rv = rv; v.rd = rd; v.br = br; v.tg = tg; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    logic [31:0] grants[$];
    logic [31:0] pcs[$];
    logic [31:0] exp_pc, paddr, prev_addr;
    logic        pending, prev_req, prev_gnt;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;
    int          delay, consumed, exp_stall;

    // fe g rv rdata br target rdy | req addr valid pc instr
    tbl[0]  = mk(0,0,0,0,0,0,0,             0,32'h00,0,0,NOOP);
    tbl[1]  = mk(1,0,0,0,0,0,0,             0,32'h00,0,0,NOOP);
    tbl[2]  = mk(1,0,0,0,0,0,1,             1,32'h80,0,0,NOOP);
    tbl[3]  = mk(1,0,0,0,0,0,1,             1,32'h80,0,0,NOOP);
    tbl[4]  = mk(1,0,0,0,0,0,1,             1,32'h80,0,0,NOOP);
    tbl[5]  = mk(1,1,0,0,0,0,1,             1,32'h80,0,0,NOOP);
    tbl[6]  = mk(1,0,1,mem(32'h80),0,0,1,   0,32'h80,0,0,NOOP);
    tbl[7]  = mk(1,1,0,0,0,0,1,             1,32'h84,1,32'h80,mem(32'h80));
    tbl[8]  = mk(1,0,1,mem(32'h84),0,0,1,   0,32'h84,0,0,NOOP);
    tbl[9]  = mk(1,1,0,0,0,0,0,             1,32'h88,1,32'h84,mem(32'h84));
    tbl[10] = mk(1,0,1,mem(32'h88),0,0,0,   0,32'h88,1,32'h84,mem(32'h84));
    tbl[11] = mk(1,0,0,0,0,0,0,             0,32'h88,1,32'h84,mem(32'h84));
    tbl[12] = mk(1,0,0,0,0,0,1,             0,32'h88,1,32'h84,mem(32'h84));
    tbl[13] = mk(1,0,0,0,0,0,0,             0,32'h88,1,32'h88,mem(32'h88));
    tbl[14] = mk(1,0,0,0,1,32'h203,1,       1,32'h8C,1,32'h88,mem(32'h88));
    tbl[15] = mk(1,1,0,0,0,0,1,             1,32'h8C,0,0,NOOP);
    tbl[16] = mk(1,0,1,32'hDEAD_BEEF,0,0,1, 0,32'h8C,0,0,NOOP);
    tbl[17] = mk(1,1,0,0,0,0,1,             1,32'h200,0,0,NOOP);
    tbl[18] = mk(1,0,1,mem(32'h200),0,0,1,  0,32'h200,0,0,NOOP);
    tbl[19] = mk(1,1,0,0,0,0,0,             1,32'h204,1,32'h200,mem(32'h200));
    tbl[20] = mk(1,0,0,0,1,32'h300,0,       0,32'h204,1,32'h200,mem(32'h200));
    tbl[21] = mk(1,0,1,32'hDEAD_BEEF,0,0,0, 0,32'h204,0,0,NOOP);
    tbl[22] = mk(1,1,0,0,0,0,0,             1,32'h300,0,0,NOOP);
    tbl[23] = mk(1,0,1,32'hDEAD_BEEF,1,32'h400,0, 0,32'h300,0,0,NOOP);
    tbl[24] = mk(0,1,0,0,0,0,1,             1,32'h400,0,0,NOOP);
    tbl[25] = mk(0,0,1,mem(32'h400),0,0,1,  0,32'h400,0,0,NOOP);
    tbl[26] = mk(0,0,0,0,0,0,1,             0,32'h400,1,32'h400,mem(32'h400));
    tbl[27] = mk(0,0,0,0,0,0,1,             0,32'h400,0,0,NOOP);

    do_reset(32'h80);
    foreach (tbl[i]) begin
      @(negedge clk);
      fetch_en = tbl[i].fe; gnt = tbl[i].g; rvalid = tbl[i].rv; rdata = tbl[i].rd;
      branch = tbl[i].br; target = tbl[i].tg; id_ready = tbl[i].rdy;
      chk($sformatf("tbl%0d_req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
    end

    // Branch while idle, fill one entry, then reset in the middle of the next transaction.
    @(negedge clk);
    idle_inputs(); fetch_en = 1'b1; branch = 1'b1; target = 32'h501;
    @(negedge clk);
    branch = 1'b0; gnt = 1'b1;
    chk("idle_br_req", {31'd0, req}, 32'd1);
    chk("idle_br_addr", addr, 32'h500);
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = mem(32'h500);
    @(negedge clk);
    rvalid = 1'b0; gnt = 1'b1;
    chk("idle_br_pc", instr_pc, 32'h500);
    chk("idle_br_next", addr, 32'h504);
    @(negedge clk);
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, req}, 32'd0);
    chk("async_rst_addr", addr, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_instr", instr, NOOP);
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_rvalid_valid", {31'd0, valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, req}, 32'd0);

    // Address wrap with a zero-wait responder; stall counter modelled alongside.
    do_reset(32'hFFFF_FFF8);
    pending = 1'b0; paddr = '0; exp_stall = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      fetch_en = 1'b1; id_ready = 1'b1;
      if (valid && !req && valid) pcs.push_back(instr_pc);
      else if (valid) pcs.push_back(instr_pc);
      if (!valid) exp_stall++;
      rvalid = pending; rdata = mem(paddr);
      gnt = req;
      if (rvalid) pending = 1'b0;
      if (gnt) begin pending = 1'b1; paddr = addr; grants.push_back(addr); end
    end
    chk("wrap_grant_count", {31'd0, grants.size() >= 3}, 32'd1);
    if (grants.size() >= 3) begin
      chk("wrap_addr0", grants[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", grants[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", grants[2], 32'h0000_0000);
    end
    chk("wrap_pc_count", {31'd0, pcs.size() >= 3}, 32'd1);
    if (pcs.size() >= 3) chk("wrap_pc2", pcs[2], 32'h0000_0000);
`ifdef IF_FETCH_PERF_EN
    @(negedge clk);
    if (!valid) exp_stall++;
    chk("stall_cnt_wrap", stall_cnt, exp_stall);
`endif

    // Randomized run against a fetch-stream model.
    do_reset($urandom & 32'h0000_FFFC);
    exp_pc = pc_start; pending = 1'b0; delay = 0; consumed = 0; exp_stall = 0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; paddr = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      s_req = req; s_addr = addr; s_valid = valid; s_pc = instr_pc; s_instr = instr;
      if (prev_req && !prev_gnt) begin
        chk("rnd_req_hold", {31'd0, s_req}, 32'd1);
        chk("rnd_addr_hold", s_addr, prev_addr);
      end
      if (pending) chk("rnd_one_outstanding", {31'd0, s_req}, 32'd0);
      if (!s_valid) chk("rnd_empty_instr", s_instr, NOOP);
      fetch_en = 1'b1;
      gnt      = s_req && (($urandom % 2) == 0);
      if (pending) rvalid = (delay == 0);
      else         rvalid = (($urandom % 8) == 0);
      rdata    = (pending && rvalid) ? mem(paddr) : $urandom;
      branch   = (($urandom % 20) == 0);
      target   = $urandom;
      id_ready = (($urandom % 4) != 0);
      if (!s_valid && id_ready) exp_stall++;
      if (branch) begin
        exp_pc = target & ~32'd3;
      end else if (s_valid && id_ready) begin
        chk("rnd_pc_order", s_pc, exp_pc);
        chk("rnd_instr_data", s_instr, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (pending) begin
        if (rvalid) pending = 1'b0;
        else delay--;
      end
      if (gnt) begin pending = 1'b1; paddr = s_addr; delay = int'($urandom % 3); end
      prev_req = s_req; prev_gnt = gnt; prev_addr = s_addr;
    end
    chk("rnd_progress", {31'd0, consumed >= 100}, 32'd1);
`ifdef IF_FETCH_PERF_EN
    chk("rnd_stall_cnt", stall_cnt, exp_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
